// File: rtl/fb_write_arbiter_pkg.sv
// Shared framebuffer definitions: screen geometry, colour constants used by
// the drawing engines, and the arbiter state encoding.
package fb_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COORD_W  = 11;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 15;

  localparam logic [COLOUR_W-1:0] BLACK   = 3'b000;
  localparam logic [COLOUR_W-1:0] MAGENTA = 3'b101;

  // GRANT0_PRIO: client 0 wins a tie (client 1 was granted last).
  // GRANT1_PRIO: client 1 wins a tie (client 0 was granted last).
  typedef enum logic {
    GRANT0_PRIO = 1'b0,
    GRANT1_PRIO = 1'b1
  } arb_state_e;

  // Row-major linear address, truncated to the framebuffer address width.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    return ADDR_W'(32'(y) * 32'(SCREEN_W) + 32'(x));
  endfunction

endpackage

// File: rtl/fb_write_arbiter_slot.sv
// One-entry holding register for a single client's pixel request.
// A load on the same edge as a drain wins, so the slot stays full with the
// new pixel.
module fb_req_slot
  import fb_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_load,
  input  logic                i_drain,
  input  logic [COORD_W-1:0]  i_x,
  input  logic [COORD_W-1:0]  i_y,
  input  logic [COLOUR_W-1:0] i_colour,
  output logic                o_full,
  output logic [COORD_W-1:0]  o_x,
  output logic [COORD_W-1:0]  o_y,
  output logic [COLOUR_W-1:0] o_colour
);

  logic                r_full;
  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic [COLOUR_W-1:0] r_colour;

  // Capture on load, empty on drain when not refilled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_full   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
    end else if (i_load) begin
      r_full   <= 1'b1;
      r_x      <= i_x;
      r_y      <= i_y;
      r_colour <= i_colour;
    end else if (i_drain) begin
      r_full   <= 1'b0;
    end
  end

  assign o_full   = r_full;
  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_colour = r_colour;

endmodule

// File: rtl/fb_write_arbiter.sv
// Two-client round-robin pixel write arbiter with off-screen clipping.
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high; reqN_ready depends only on internal state
// (slot empty, or slot being granted this cycle) and never on reqN_valid.
// Pipeline: slot -> P1 (grant) -> registered framebuffer write.
module fb_write_arbiter
  import fb_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic [COORD_W-1:0]  req0_x,
  input  logic [COORD_W-1:0]  req0_y,
  input  logic [COLOUR_W-1:0] req0_colour,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [COORD_W-1:0]  req1_x,
  input  logic [COORD_W-1:0]  req1_y,
  input  logic [COLOUR_W-1:0] req1_colour,
  input  logic                req1_valid,
  output logic                req1_ready,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [COLOUR_W-1:0] fb_data,
  output logic                fb_wren,
  output logic [7:0]          clip_count,
  output logic                busy,
  output arb_state_e          arb_state
);

  logic                w_full0, w_full1;
  logic [COORD_W-1:0]  w_x0, w_y0, w_x1, w_y1;
  logic [COLOUR_W-1:0] w_c0, w_c1;
  logic                w_grant0, w_grant1;
  logic                w_load0, w_load1;
  logic                w_in_range;

  arb_state_e          r_state;
  logic                r_p1_valid;
  logic [COORD_W-1:0]  r_p1_x, r_p1_y;
  logic [COLOUR_W-1:0] r_p1_colour;
  logic                r_fb_wren;
  logic [ADDR_W-1:0]   r_fb_addr;
  logic [COLOUR_W-1:0] r_fb_data;
  logic [7:0]          r_clip_count;

  // Tie goes to the client favoured by the current priority state.
  assign w_grant0 = w_full0 & (!w_full1 | (r_state == GRANT0_PRIO));
  assign w_grant1 = w_full1 & (!w_full0 | (r_state == GRANT1_PRIO));

  assign req0_ready = !w_full0 | w_grant0;
  assign req1_ready = !w_full1 | w_grant1;
  assign w_load0    = req0_valid & req0_ready;
  assign w_load1    = req1_valid & req1_ready;

  fb_req_slot u_slot0 (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_load   (w_load0),
    .i_drain  (w_grant0),
    .i_x      (req0_x),
    .i_y      (req0_y),
    .i_colour (req0_colour),
    .o_full   (w_full0),
    .o_x      (w_x0),
    .o_y      (w_y0),
    .o_colour (w_c0)
  );

  fb_req_slot u_slot1 (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_load   (w_load1),
    .i_drain  (w_grant1),
    .i_x      (req1_x),
    .i_y      (req1_y),
    .i_colour (req1_colour),
    .o_full   (w_full1),
    .o_x      (w_x1),
    .o_y      (w_y1),
    .o_colour (w_c1)
  );

  // Priority FSM: after a grant, the other client gets the next tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= GRANT0_PRIO;
    end else begin
      case (r_state)
        GRANT0_PRIO: if (w_grant0) r_state <= GRANT1_PRIO;
        GRANT1_PRIO: if (w_grant1) r_state <= GRANT0_PRIO;
        default:     r_state <= GRANT0_PRIO;
      endcase
    end
  end

  // P1: holds the granted pixel for one cycle ahead of the clip/address stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_p1_valid  <= 1'b0;
      r_p1_x      <= '0;
      r_p1_y      <= '0;
      r_p1_colour <= '0;
    end else begin
      r_p1_valid <= w_grant0 | w_grant1;
      if (w_grant0) begin
        r_p1_x      <= w_x0;
        r_p1_y      <= w_y0;
        r_p1_colour <= w_c0;
      end else if (w_grant1) begin
        r_p1_x      <= w_x1;
        r_p1_y      <= w_y1;
        r_p1_colour <= w_c1;
      end
    end
  end

  // Unsigned compare, so negative coordinates wrap large and are clipped.
  assign w_in_range = (r_p1_x < COORD_W'(SCREEN_W)) & (r_p1_y < COORD_W'(SCREEN_H));

  // Output stage: single-cycle write strobe, or count a clipped pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fb_wren    <= 1'b0;
      r_fb_addr    <= '0;
      r_fb_data    <= '0;
      r_clip_count <= '0;
    end else begin
      r_fb_wren <= 1'b0;
      if (r_p1_valid) begin
        if (w_in_range) begin
          r_fb_wren <= 1'b1;
          r_fb_addr <= lin_addr(r_p1_x, r_p1_y);
          r_fb_data <= r_p1_colour;
        end else if (r_clip_count != 8'hFF) begin
          r_clip_count <= r_clip_count + 8'd1;
        end
      end
    end
  end

  assign fb_wren    = r_fb_wren;
  assign fb_addr    = r_fb_addr;
  assign fb_data    = r_fb_data;
  assign clip_count = r_clip_count;
  assign busy       = w_full0 | w_full1 | r_p1_valid | r_fb_wren;
  assign arb_state  = r_state;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboarded bench for fb_write_arbiter: a transaction-level model of two
// request slots and round-robin grants predicts each framebuffer write with
// the cycle it must appear in; a monitor checks the DUT against that queue.
module tb_fb_write_arbiter;
  import fb_pkg::*;

  localparam int EXP_W = 32 + ADDR_W + COLOUR_W;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic [COORD_W-1:0]  req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic [COLOUR_W-1:0] req0_colour = '0, req1_colour = '0;
  logic                req0_valid = 1'b0, req1_valid = 1'b0;
  logic                req0_ready, req1_ready;
  logic [ADDR_W-1:0]   fb_addr;
  logic [COLOUR_W-1:0] fb_data;
  logic                fb_wren;
  logic [7:0]          clip_count;
  logic                busy;
  arb_state_e          arb_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  int unsigned cyc = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;

  // Reference model state: slot contents, last granted client, clip total.
  bit                  m_full[2];
  logic [COORD_W-1:0]  m_x[2];
  logic [COORD_W-1:0]  m_y[2];
  logic [COLOUR_W-1:0] m_c[2];
  int                  m_last;
  int                  m_clip;
  int                  m_acc_total;
  bit                  acc0, acc1;

  fb_write_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0_x      (req0_x),
    .req0_y      (req0_y),
    .req0_colour (req0_colour),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req1_x      (req1_x),
    .req1_y      (req1_y),
    .req1_colour (req1_colour),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_wren     (fb_wren),
    .clip_count  (clip_count),
    .busy        (busy),
    .arb_state   (arb_state)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_last = 1;
    m_clip = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of requests and advance the model across the next edge.
  task automatic step(input bit v0, input int x0, input int y0, input int c0,
                      input bit v1, input int x1, input int y1, input int c1);
    int g;
    bit r0, r1;
    int a;
    @(negedge clock);
    req0_valid = v0; req0_x = COORD_W'(x0); req0_y = COORD_W'(y0); req0_colour = COLOUR_W'(c0);
    req1_valid = v1; req1_x = COORD_W'(x1); req1_y = COORD_W'(y1); req1_colour = COLOUR_W'(c1);
    if (m_full[0] && m_full[1]) g = (m_last == 1) ? 0 : 1;
    else if (m_full[0])         g = 0;
    else if (m_full[1])         g = 1;
    else                        g = -1;
    r0 = !m_full[0] || (g == 0);
    r1 = !m_full[1] || (g == 1);
    check("ready0", {31'd0, req0_ready}, {31'd0, r0});
    check("ready1", {31'd0, req1_ready}, {31'd0, r1});
    if (g >= 0) begin
      if (int'(m_x[g]) < SCREEN_W && int'(m_y[g]) < SCREEN_H) begin
        a = int'(m_y[g]) * SCREEN_W + int'(m_x[g]);
        exp_q.push_back({cyc + 32'd2, a[ADDR_W-1:0], m_c[g]});
      end else if (m_clip < 255) begin
        m_clip++;
      end
      m_last = g;
      m_full[g] = 0;
    end
    acc0 = v0 && r0;
    acc1 = v1 && r1;
    if (acc0) begin
      m_full[0] = 1; m_x[0] = req0_x; m_y[0] = req0_y; m_c[0] = req0_colour;
      m_acc_total++;
    end
    if (acc1) begin
      m_full[1] = 1; m_x[1] = req1_x; m_y[1] = req1_y; m_c[1] = req1_colour;
      m_acc_total++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(input string tag);
    idle(6);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_clip"}, {24'd0, clip_count}, m_clip);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  // Monitor: every write must match the head of the queue in the predicted cycle.
  always @(negedge clock) begin
    if (fb_wren === 1'b1) n_writes++;
    if (exp_q.size() > 0 && exp_q[0][EXP_W-1 -: 32] == cyc) begin
      mon_e = exp_q.pop_front();
      n_tests++;
      if (fb_wren !== 1'b1 || fb_addr !== mon_e[COLOUR_W +: ADDR_W] || fb_data !== mon_e[COLOUR_W-1:0]) begin
        n_fail++;
        $display("FAIL write@%0d: wren=%0b addr=%0d data=%0d expected wren=1 addr=%0d data=%0d",
                 cyc, fb_wren, fb_addr, fb_data, mon_e[COLOUR_W +: ADDR_W], mon_e[COLOUR_W-1:0]);
      end
    end else if (fb_wren !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_write@%0d: wren=%0b addr=%0d expected wren=0", cyc, fb_wren, fb_addr);
    end
  end

  initial begin
    int x0, x1, w_before, acc_before;
    model_reset();
    m_acc_total = 0;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_wren",  {31'd0, fb_wren}, 32'd0);
    check("rst_addr",  {17'd0, fb_addr}, 32'd0);
    check("rst_data",  {29'd0, fb_data}, 32'd0);
    check("rst_clip",  {24'd0, clip_count}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_state", 32'(arb_state), 32'(GRANT0_PRIO));
    reset_n = 1'b1;

    // Single write
    step(1, 20, 80, MAGENTA, 0, 0, 0, 0);
    drain("single");
    check("single_addr", {17'd0, fb_addr}, 32'd12820);
    check("single_data", {29'd0, fb_data}, 32'(MAGENTA));

    // Clipping at both edges, then the last visible pixel
    step(0, 0, 0, 0, 1, 160, 0, 2);
    step(0, 0, 0, 0, 1, 0, 120, 3);
    drain("clip");
    check("clip_two", {24'd0, clip_count}, 32'd2);
    step(0, 0, 0, 0, 1, 159, 119, 6);
    drain("corner");
    check("corner_addr", {17'd0, fb_addr}, 32'd19199);

    // Simultaneous requests
    step(1, 1, 1, 1, 1, 2, 2, 2);
    drain("simul");

    // Sustained contention, x advancing per accepted request
    x0 = 0; x1 = 0;
    w_before = n_writes;
    acc_before = m_acc_total;
    for (int i = 0; i < 20; i++) begin
      step(1, x0, 10, 1, 1, x1, 20, 4);
      if (acc0) x0++;
      if (acc1) x1++;
    end
    drain("contend");
    check("contend_writes", n_writes - w_before, m_acc_total - acc_before);

    // Randomized traffic, including occasional wrapped/off-screen coordinates
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 170),
           ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 125),
           $urandom_range(0, 7),
           $urandom_range(0, 2) != 0,
           ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 170),
           ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 125),
           $urandom_range(0, 7));
    end
    drain("random");

    // Clip counter saturation
    for (int i = 0; i < 300; i++) step(1, 2000 + (i % 40), $urandom_range(0, 2047), 1, 0, 0, 0, 0);
    drain("sat");
    check("sat_255", {24'd0, clip_count}, 32'd255);
    idle(3);
    check("sat_hold", {24'd0, clip_count}, 32'd255);

    // Reset with both slots full and P1 loaded
    step(1, 30, 40, 1, 1, 50, 60, 2);
    step(1, 31, 40, 3, 1, 51, 60, 4);
    @(posedge clock);
    #2;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_wren", {31'd0, fb_wren}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_clip", {24'd0, clip_count}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle(6);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    step(0, 0, 0, 0, 1, 5, 5, 7);
    drain("postrst");
    check("postrst_addr", {17'd0, fb_addr}, 32'd805);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
